// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low digit codes (bit0=a .. bit6=g),
// the blank pattern and the reader tracking-state type.
package seg7_pkg;

   localparam logic [6:0] SEG_CODE_0 = 7'b1000000;
   localparam logic [6:0] SEG_CODE_1 = 7'b1111001;
   localparam logic [6:0] SEG_CODE_2 = 7'b0100100;
   localparam logic [6:0] SEG_CODE_3 = 7'b0110000;
   localparam logic [6:0] SEG_CODE_4 = 7'b0011001;
   localparam logic [6:0] SEG_CODE_5 = 7'b0010010;
   localparam logic [6:0] SEG_CODE_6 = 7'b0000010;
   localparam logic [6:0] SEG_CODE_7 = 7'b1111000;
   localparam logic [6:0] SEG_BLANK  = 7'h7F;

   typedef enum logic {
      TRACK  = 1'b0,
      LOCKED = 1'b1
   } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup: active-low segment pattern -> digit value and legality.
// Illegal patterns report value 0.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern_i,
   output logic [2:0] value_o,
   output logic       legal_o
);

   always_comb begin
      value_o = '0;
      legal_o = 1'b1;
      case (pattern_i)
         SEG_CODE_0: value_o = 3'd0;
         SEG_CODE_1: value_o = 3'd1;
         SEG_CODE_2: value_o = 3'd2;
         SEG_CODE_3: value_o = 3'd3;
         SEG_CODE_4: value_o = 3'd4;
         SEG_CODE_5: value_o = 3'd5;
         SEG_CODE_6: value_o = 3'd6;
         SEG_CODE_7: value_o = 3'd7;
         default:    legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_reader.sv
// Debounced seven-segment reader: accepts a pattern after STABLE_CYCLES equal
// enabled samples and presents the decoded digit on a valid/ready output.
// Optional feature macro: SEG7_READER_ERRCNT_EN adds the err_count output.
module seg7_reader
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_in,
   input  logic       sample_en,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out_value,
   output logic       out_err,
   output logic       overrun
`ifdef SEG7_READER_ERRCNT_EN
   ,output logic [7:0] err_count
`endif
);

   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

   seg7_state_e state_q, state_d;
   logic [6:0]  sample_q, sample_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        valid_q, valid_d;
   logic [2:0]  value_q, value_d;
   logic        err_q, err_d;
   logic        over_q, over_d;
   logic        differs, accept, emit, busy;
   logic [2:0]  dec_value;
   logic        dec_legal;

   seg7_pattern_decode u_decode (
      .pattern_i (sample_q),
      .value_o   (dec_value),
      .legal_o   (dec_legal)
   );

   always_comb begin
      differs  = (seg_in != sample_q);
      accept   = (state_q == TRACK) && (cnt_q == STABLE);
      emit     = accept && (sample_q != SEG_BLANK);
      busy     = valid_q && !out_ready;

      sample_d = sample_q;
      cnt_d    = cnt_q;
      if (sample_en) begin
         sample_d = seg_in;
         if (differs)
            cnt_d = 4'd1;
         else if (cnt_q != STABLE)
            cnt_d = cnt_q + 4'd1;
      end

      // A differing sample on the acceptance cycle itself restarts tracking at once.
      state_d = state_q;
      if (accept)
         state_d = (sample_en && differs) ? TRACK : LOCKED;
      else if ((state_q == LOCKED) && sample_en && differs)
         state_d = TRACK;

      valid_d = valid_q;
      value_d = value_q;
      err_d   = err_q;
      if (emit && !busy) begin
         valid_d = 1'b1;
         value_d = dec_legal ? dec_value : 3'd0;
         err_d   = !dec_legal;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end

      over_d = over_q | (emit && busy);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= TRACK;
         sample_q <= SEG_BLANK;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         value_q  <= '0;
         err_q    <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sample_q <= sample_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         value_q  <= value_d;
         err_q    <= err_d;
         over_q   <= over_d;
      end
   end

   assign out_valid = valid_q;
   assign out_value = value_q;
   assign out_err   = err_q;
   assign overrun   = over_q;

`ifdef SEG7_READER_ERRCNT_EN
   logic [7:0] errcnt_q, errcnt_d;

   always_comb begin
      errcnt_d = errcnt_q;
      if (emit && !dec_legal && (errcnt_q != 8'hFF))
         errcnt_d = errcnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         errcnt_q <= '0;
      else
         errcnt_q <= errcnt_d;
   end

   assign err_count = errcnt_q;
`endif

endmodule
